// File: rtl/maxnet_pkg.sv
// maxnet_pkg: shared types and defaults for the Maxnet iteration sequencer.
//   state_t    - sequencer state encoding (3 bits)
//   nz_class_t - classification of the per-neuron nonzero flags
package maxnet_pkg;

   localparam int unsigned N_NEURONS_DEF = 4;
   localparam int unsigned ITER_W_DEF    = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      CHECK  = 3'd2,
      START  = 3'd3,
      WAIT   = 3'd4,
      UPDATE = 3'd5,
      FINISH = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      NZ_NONE = 2'd0,
      NZ_ONE  = 2'd1,
      NZ_MANY = 2'd2
   } nz_class_t;

endpackage

// File: rtl/maxnet_nz_classify.sv
// maxnet_nz_classify: combinational popcount of the nonzero flags, reduced to
// none / exactly one / more than one.
//   nz       in  N   per-neuron nonzero flags
//   nz_class out     classification (nz_class_t)
module maxnet_nz_classify
   import maxnet_pkg::*;
#(
   parameter int unsigned N = N_NEURONS_DEF
) (
   input  logic [N-1:0] nz,
   output nz_class_t    nz_class
);

   localparam int unsigned CNT_W = $clog2(N + 1);

   logic [CNT_W-1:0] cnt;

   // Population count of nz.
   always_comb begin
      cnt = '0;
      for (int i = 0; i < int'(N); i++) begin
         cnt = cnt + CNT_W'(nz[i]);
      end
   end

   always_comb begin
      nz_class = NZ_MANY;
      if (cnt == CNT_W'(0)) begin
         nz_class = NZ_NONE;
      end else if (cnt == CNT_W'(1)) begin
         nz_class = NZ_ONE;
      end
   end

endmodule

// File: rtl/maxnet_cnt.sv
// maxnet_cnt: Maxnet iteration sequencer, initiator side of the PLU
// start/done handshake. Loads activations, fires the PLUs until exactly one
// neuron stays nonzero, then reports it as a one-hot winner.
//   clk, rst    clock, synchronous active-high reset
//   start       run request (IDLE only)
//   nz          per-neuron nonzero flags (CHECK only)
//   plu_done    PLU completion pulse (WAIT only)
//   in_we       load initial activations (LOAD)
//   plu_start   PLU start pulse (START)
//   upd_we      write back PLU outputs (UPDATE)
//   busy        not IDLE
//   done        completion pulse (FINISH)
//   winner      one-hot survivor, zero on error
//   err         no winner / iteration limit hit
//   iter_cnt    completed PLU iterations, saturating
// Optional: MAXNET_ITER_LIMIT_EN enables the MAX_ITER iteration limit.
module maxnet_cnt
   import maxnet_pkg::*;
#(
   parameter int unsigned N_NEURONS = N_NEURONS_DEF,
   parameter int unsigned ITER_W    = ITER_W_DEF,
   parameter int unsigned MAX_ITER  = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [N_NEURONS-1:0] nz,
   input  logic                 plu_done,
   output logic                 in_we,
   output logic                 plu_start,
   output logic                 upd_we,
   output logic                 busy,
   output logic                 done,
   output logic [N_NEURONS-1:0] winner,
   output logic                 err,
   output logic [ITER_W-1:0]    iter_cnt
);

`ifdef MAXNET_ITER_LIMIT_EN
   localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);
`endif

   state_t    state;
   nz_class_t nz_class;

   maxnet_nz_classify #(
      .N (N_NEURONS)
   ) u_classify (
      .nz       (nz),
      .nz_class (nz_class)
   );

   // Sequencer state plus the registered result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         winner   <= '0;
         err      <= 1'b0;
         iter_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) state <= LOAD;
            end
            LOAD: begin
               iter_cnt <= '0;
               err      <= 1'b0;
               winner   <= '0;
               state    <= CHECK;
            end
            CHECK: begin
               case (nz_class)
                  NZ_NONE: begin
                     err    <= 1'b1;
                     winner <= '0;
                     state  <= FINISH;
                  end
                  NZ_ONE: begin
                     err    <= 1'b0;
                     winner <= nz;
                     state  <= FINISH;
                  end
                  default: begin
`ifdef MAXNET_ITER_LIMIT_EN
                     if (iter_cnt == ITER_LIMIT) begin
                        err    <= 1'b1;
                        winner <= '0;
                        state  <= FINISH;
                     end else begin
                        state <= START;
                     end
`else
                     state <= START;
`endif
                  end
               endcase
            end
            START: begin
               state <= WAIT;
            end
            WAIT: begin
               if (plu_done) state <= UPDATE;
            end
            UPDATE: begin
               // Saturate rather than wrap so a long run never looks short.
               if (iter_cnt != '1) iter_cnt <= iter_cnt + ITER_W'(1);
               state <= CHECK;
            end
            FINISH: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Moore decode of the handshake strobes.
   assign in_we     = (state == LOAD);
   assign plu_start = (state == START);
   assign upd_we    = (state == UPDATE);
   assign done      = (state == FINISH);
   assign busy      = (state != IDLE);

endmodule
